// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded instruction fields in, registered EX fields and
// stall/bubble status out. The stage itself attaches through the slave modport.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_imm;
  logic              id_wmem;
  logic              id_rmem;
  logic              id_wreg;
  logic [2:0]        id_alu;
  logic [1:0]        id_ext;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic [RA_W-1:0]   id_rd;
  logic [DATA_W-1:0] id_opa;
  logic [DATA_W-1:0] id_opb;
  logic [DATA_W-1:0] id_imm_val;
  logic              flush;
  logic              hold;

  logic              ex_valid;
  logic              ex_imm;
  logic              ex_wmem;
  logic              ex_rmem;
  logic              ex_wreg;
  logic [2:0]        ex_alu;
  logic [1:0]        ex_ext;
  logic [RA_W-1:0]   ex_rd;
  logic [DATA_W-1:0] ex_opa;
  logic [DATA_W-1:0] ex_opb;
  logic [DATA_W-1:0] ex_imm_val;
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_imm, id_wmem, id_rmem, id_wreg, id_alu, id_ext,
           id_rs1, id_rs2, id_rd, id_opa, id_opb, id_imm_val, flush, hold,
    input  ex_valid, ex_imm, ex_wmem, ex_rmem, ex_wreg, ex_alu, ex_ext,
           ex_rd, ex_opa, ex_opb, ex_imm_val, id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_imm, id_wmem, id_rmem, id_wreg, id_alu, id_ext,
           id_rs1, id_rs2, id_rd, id_opa, id_opb, id_imm_val, flush, hold,
    output ex_valid, ex_imm, ex_wmem, ex_rmem, ex_wreg, ex_alu, ex_ext,
           ex_rd, ex_opa, ex_opb, ex_imm_val, id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              imm;
    logic              wmem;
    logic              rmem;
    logic              wreg;
    logic [2:0]        alu;
    logic [1:0]        ext;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm_val;
  } ex_t;

  ex_t              ex_reg;
  ex_t              ex_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             hz;
  logic             rd_match;

  // An immediate-form instruction has no second register source, so rs2 is ignored.
  assign rd_match = (ex_reg.rd == bus.id_rs1) |
                    (~bus.id_imm & (ex_reg.rd == bus.id_rs2));
  assign hz = ex_reg.valid & ex_reg.rmem & bus.id_valid &
              (ex_reg.rd != '0) & rd_match;

  assign bus.id_stall = bus.hold | (hz & ~bus.flush);

  always_comb begin
    ex_next  = ex_reg;
    cnt_next = cnt_reg;
    if (bus.flush) begin
      ex_next = '0;
    end else if (bus.hold) begin
      ex_next = ex_reg;
    end else if (hz) begin
      ex_next  = '0;
      cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    end else if (bus.id_valid) begin
      ex_next.valid   = 1'b1;
      ex_next.imm     = bus.id_imm;
      ex_next.wmem    = bus.id_wmem;
      ex_next.rmem    = bus.id_rmem;
      ex_next.wreg    = bus.id_wreg;
      ex_next.alu     = bus.id_alu;
      ex_next.ext     = bus.id_ext;
      ex_next.rd      = bus.id_rd;
      ex_next.opa     = bus.id_opa;
      ex_next.opb     = bus.id_opb;
      ex_next.imm_val = bus.id_imm_val;
    end else begin
      ex_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      ex_reg  <= ex_next;
      cnt_reg <= cnt_next;
    end
  end

  assign bus.ex_valid   = ex_reg.valid;
  assign bus.ex_imm     = ex_reg.imm;
  assign bus.ex_wmem    = ex_reg.wmem;
  assign bus.ex_rmem    = ex_reg.rmem;
  assign bus.ex_wreg    = ex_reg.wreg;
  assign bus.ex_alu     = ex_reg.alu;
  assign bus.ex_ext     = ex_reg.ext;
  assign bus.ex_rd      = ex_reg.rd;
  assign bus.ex_opa     = ex_reg.opa;
  assign bus.ex_opb     = ex_reg.opb;
  assign bus.ex_imm_val = ex_reg.imm_val;
  assign bus.bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed checks of id_ex_stage; a second instance with a 3-bit counter
// shadows the same stimulus so saturation can be reached in few cycles.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .RA_W(4), .CNT_W(16)) bif ();
  id_ex_stage_if #(.DATA_W(32), .RA_W(4), .CNT_W(3))  bifs ();

  id_ex_stage #(.DATA_W(32), .RA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave)
  );
  id_ex_stage #(.DATA_W(32), .RA_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(bifs.slave)
  );

  assign bifs.id_valid   = bif.id_valid;
  assign bifs.id_imm     = bif.id_imm;
  assign bifs.id_wmem    = bif.id_wmem;
  assign bifs.id_rmem    = bif.id_rmem;
  assign bifs.id_wreg    = bif.id_wreg;
  assign bifs.id_alu     = bif.id_alu;
  assign bifs.id_ext     = bif.id_ext;
  assign bifs.id_rs1     = bif.id_rs1;
  assign bifs.id_rs2     = bif.id_rs2;
  assign bifs.id_rd      = bif.id_rd;
  assign bifs.id_opa     = bif.id_opa;
  assign bifs.id_opb     = bif.id_opb;
  assign bifs.id_imm_val = bif.id_imm_val;
  assign bifs.flush      = bif.flush;
  assign bifs.hold       = bif.hold;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rmem, input logic imm,
                     input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                     input logic [2:0] alu, input logic [31:0] opa, input logic [31:0] opb);
    bif.id_valid   = v;
    bif.id_rmem    = rmem;
    bif.id_imm     = imm;
    bif.id_wmem    = 1'b0;
    bif.id_wreg    = v;
    bif.id_alu     = alu;
    bif.id_ext     = 2'b01;
    bif.id_rs1     = rs1;
    bif.id_rs2     = rs2;
    bif.id_rd      = rd;
    bif.id_opa     = opa;
    bif.id_opb     = opb;
    bif.id_imm_val = 32'h0000_0F0F;
  endtask

  initial begin
    // Reset with random inputs: everything reads as a bubble
    bif.flush      = 1'b0;
    bif.hold       = 1'b0;
    bif.id_valid   = 1'b1;
    bif.id_imm     = 1'($urandom);
    bif.id_wmem    = 1'b1;
    bif.id_rmem    = 1'($urandom);
    bif.id_wreg    = 1'b1;
    bif.id_alu     = 3'($urandom);
    bif.id_ext     = 2'($urandom);
    bif.id_rs1     = 4'($urandom);
    bif.id_rs2     = 4'($urandom);
    bif.id_rd      = 4'($urandom);
    bif.id_opa     = $urandom;
    bif.id_opb     = $urandom;
    bif.id_imm_val = $urandom;
    #2;
    check("rst_ex_valid", 64'(bif.ex_valid), 64'd0);
    check("rst_ex_wreg",  64'(bif.ex_wreg),  64'd0);
    check("rst_ex_wmem",  64'(bif.ex_wmem),  64'd0);
    check("rst_ex_opa",   64'(bif.ex_opa),   64'd0);
    check("rst_cnt",      64'(bif.bubble_cnt), 64'd0);
    check("rst_stall",    64'(bif.id_stall), 64'd0);
    tick();
    check("rst_edge_valid", 64'(bif.ex_valid), 64'd0);
    check("rst_edge_rd",    64'(bif.ex_rd),    64'd0);
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'd0, 32'd0, 32'd0);
    #1 rst = 1'b1;
    tick();

    // Plain advance
    drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 3'b101, 32'h12, 32'h34);
    tick();
    check("adv_valid", 64'(bif.ex_valid), 64'd1);
    check("adv_alu",   64'(bif.ex_alu),   64'd5);
    check("adv_rd",    64'(bif.ex_rd),    64'd4);
    check("adv_opa",   64'(bif.ex_opa),   64'h12);
    check("adv_wreg",  64'(bif.ex_wreg),  64'd1);

    // Load rd=3, then a consumer reading r3 through rs2
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h100, 32'h0);
    #1 check("ld_nostall", 64'(bif.id_stall), 64'd0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 4'd5, 4'd3, 4'd6, 3'd1, 32'hAA, 32'hBB);
    #1 check("lu_stall", 64'(bif.id_stall), 64'd1);
    tick();
    check("lu_bub_valid", 64'(bif.ex_valid), 64'd0);
    check("lu_bub_wreg",  64'(bif.ex_wreg),  64'd0);
    check("lu_bub_rd",    64'(bif.ex_rd),    64'd0);
    check("lu_cnt",       64'(bif.bubble_cnt), 64'd1);
    check("lu_cnt_sat",   64'(bifs.bubble_cnt), 64'd1);
    check("lu_stall_clr", 64'(bif.id_stall), 64'd0);
    tick();
    check("lu_cap_valid", 64'(bif.ex_valid), 64'd1);
    check("lu_cap_rd",    64'(bif.ex_rd),    64'd6);
    check("lu_cap_opb",   64'(bif.ex_opb),   64'hBB);
    check("lu_cap_cnt",   64'(bif.bubble_cnt), 64'd1);

    // Same dependency through rs2 but immediate form: no hazard
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h100, 32'h0);
    tick();
    drv(1'b1, 1'b0, 1'b1, 4'd5, 4'd3, 4'd7, 3'd2, 32'hCC, 32'hDD);
    #1 check("imm_stall", 64'(bif.id_stall), 64'd0);
    tick();
    check("imm_valid", 64'(bif.ex_valid), 64'd1);
    check("imm_imm",   64'(bif.ex_imm),   64'd1);
    check("imm_cnt",   64'(bif.bubble_cnt), 64'd1);

    // Load to r0 never blocks a reader of r0
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 3'd0, 32'h200, 32'h0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd8, 3'd3, 32'hEE, 32'hFF);
    #1 check("r0_stall", 64'(bif.id_stall), 64'd0);
    tick();
    check("r0_valid", 64'(bif.ex_valid), 64'd1);
    check("r0_rd",    64'(bif.ex_rd),    64'd8);
    check("r0_cnt",   64'(bif.bubble_cnt), 64'd1);

    // Flush beats the hazard: bubble, count unchanged, no stall
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h300, 32'h0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd9, 3'd4, 32'h11, 32'h22);
    bif.flush = 1'b1;
    #1 check("fl_stall", 64'(bif.id_stall), 64'd0);
    tick();
    bif.flush = 1'b0;
    check("fl_valid", 64'(bif.ex_valid), 64'd0);
    check("fl_rd",    64'(bif.ex_rd),    64'd0);
    check("fl_cnt",   64'(bif.bubble_cnt), 64'd1);

    // Hold with a pending hazard freezes the load in EX
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h400, 32'h0);
    tick();
    drv(1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd10, 3'd4, 32'h33, 32'h44);
    bif.hold = 1'b1;
    #1 check("hold_stall", 64'(bif.id_stall), 64'd1);
    tick();
    tick();
    tick();
    check("hold_valid", 64'(bif.ex_valid), 64'd1);
    check("hold_rmem",  64'(bif.ex_rmem),  64'd1);
    check("hold_rd",    64'(bif.ex_rd),    64'd3);
    check("hold_opa",   64'(bif.ex_opa),   64'h400);
    check("hold_cnt",   64'(bif.bubble_cnt), 64'd1);
    check("hold_stall2", 64'(bif.id_stall), 64'd1);

    // Reset in the middle of the hold: immediate bubble, counter cleared
    rst = 1'b0;
    #1;
    check("rh_valid", 64'(bif.ex_valid), 64'd0);
    check("rh_rd",    64'(bif.ex_rd),    64'd0);
    check("rh_cnt",   64'(bif.bubble_cnt), 64'd0);
    check("rh_stall", 64'(bif.id_stall), 64'd1);
    bif.hold = 1'b0;
    #1 check("rh_stall_nohold", 64'(bif.id_stall), 64'd0);
    rst = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 3'b101, 32'h55, 32'h0);
    tick();
    check("rel_valid", 64'(bif.ex_valid), 64'd1);
    check("rel_opa",   64'(bif.ex_opa),   64'h55);

    // Flush beats hold
    drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h500, 32'h0);
    tick();
    bif.hold  = 1'b1;
    bif.flush = 1'b1;
    tick();
    bif.hold  = 1'b0;
    bif.flush = 1'b0;
    check("flhold_valid", 64'(bif.ex_valid), 64'd0);
    check("flhold_cnt",   64'(bif.bubble_cnt), 64'd0);

    // Ten load-use bubbles: wide counter counts, 3-bit counter pins at 7
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 3'd0, 32'h600, 32'h0);
      tick();
      drv(1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd5, 3'd0, 32'h0, 32'h0);
      tick();
    end
    check("sat_wide", 64'(bif.bubble_cnt),  64'd10);
    check("sat_narrow", 64'(bifs.bubble_cnt), 64'd7);
    check("sat_bub_wmem", 64'(bifs.ex_wmem), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, operand width.
REQ-002 Parameter RA_W, 4, register address width.
REQ-003 Parameter CNT_W, 16, width of bubble counter.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 id_valid  in  1  decode stage holds a real instruction.
REQ-007 id_imm, id_wmem, id_rmem, id_wreg  in  1 each  decoded control bits from the control unit.
REQ-008 id_alu  in  3  decoded ALU operation; id_ext  in  2  decoded extend select.
REQ-009 id_rs1, id_rs2, id_rd  in  RA_W  source and destination register numbers.
REQ-010 id_opa, id_opb, id_imm_val  in  DATA_W  register operands and extended immediate.
REQ-011 flush  in  1  downstream redirect; discard the decode-stage instruction.
REQ-012 hold  in  1  downstream stall (memory busy); freeze stage.
REQ-013 ex_valid, ex_imm, ex_wmem, ex_rmem, ex_wreg  out  1 each  registered controls.
REQ-014 ex_alu  out  3; ex_ext  out  2; ex_rd  out  RA_W; ex_opa, ex_opb, ex_imm_val  out  DATA_W  registered fields.
REQ-015 id_stall  out  1  combinational; upstream shall not advance fetch/decode this cycle.
REQ-016 bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-017 Registered outputs update only on rising clk edge; id_stall combinational from registered EX state and ID inputs.
REQ-018 Load-use hazard hz = ex_valid & ex_rmem & id_valid & ex_rd != 0 & (ex_rd == id_rs1 | (~id_imm & ex_rd == id_rs2)).
REQ-019 Register 0 never creates a hazard.
REQ-020 id_stall = hold | (hz & ~flush).
REQ-021 Per-edge priority: flush > hold > hz > normal advance.
REQ-022 flush=1: load bubble (REQ-026) regardless of hold or hz; bubble_cnt unchanged.
REQ-023 flush=0, hold=1: all ex_* registers and bubble_cnt retain value.
REQ-024 flush=0, hold=0, hz=1: load bubble; bubble_cnt += 1, saturating at all-ones.
REQ-025 Otherwise: capture all id_* into ex_*; ex_valid = id_valid; when id_valid=0 load bubble instead.
REQ-026 Bubble: ex_valid, ex_imm, ex_wmem, ex_rmem, ex_wreg = 0; ex_alu, ex_ext, ex_rd = 0; data fields = 0.
REQ-027 Latency: one cycle from ID inputs to ex_* outputs; load-use stall lasts exactly one cycle when hold=0, since the bubble clears hz.
REQ-028 hold asserted for N cycles freezes stage N cycles; hz re-evaluated each cycle against frozen EX contents.
REQ-029 No ex_* field of a bubble may carry ex_wmem=1 or ex_wreg=1 (no spurious side effects).

Reset
REQ-030 rst=0 asynchronously forces bubble state (REQ-026) and bubble_cnt=0 without waiting for clk.
REQ-031 During reset id_stall = hold (ex_valid=0 ⇒ hz=0).
REQ-032 Reset asserted mid-stall or mid-hold aborts it; first edge after release behaves per REQ-025.
REQ-033 Release is synchronous to clk edges; no capture on the edge coincident with deassertion is required.

Verification
REQ-034 Reset: rst=0 with all inputs random -> all ex_* = 0, bubble_cnt=0, id_stall=0 (hold=0).
REQ-035 Advance: id_valid=1, id_wreg=1, id_alu=3'b101, id_rd=4, id_opa=32'h12 -> next edge ex_valid=1, ex_alu=5, ex_rd=4, ex_opa=32'h12.
REQ-036 Load-use: EX holds rmem=1, rd=3; ID rs2=3, id_imm=0 -> id_stall=1, next edge bubble, bubble_cnt=1; following cycle id_stall=0, instruction captured; repeat with id_imm=1 -> no stall.
REQ-037 Zero register: EX load with rd=0, ID rs1=0 -> id_stall=0, no bubble.
REQ-038 Priority: hz=1 and flush=1 same cycle -> bubble, bubble_cnt unchanged, id_stall=0; hold=1 with hz=1 -> all ex_* frozen, id_stall=1.
REQ-039 Saturation/reset mid-op: preload bubble_cnt to 16'hFFFF, force hz -> stays 16'hFFFF; assert rst during hold -> immediate bubble, bubble_cnt=0.
